// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder.
// Holds the sequencer state encoding and width helpers.
package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-facing bundle of the UART transmit feeder.
// The feeder uses the slave view; the surrounding logic drives master.
interface uart_tx_feeder_if #(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH = 8
);
  import uart_tx_feeder_pkg::*;

  localparam int CW = CeilLog2(DEPTH + 1);

  logic [WORD_LENGHT-1:0] wr_data;
  logic                   wr_en;
  logic                   flush;
  logic                   Tx_ready;
  logic [WORD_LENGHT-1:0] Tx_in;
  logic                   send;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   overflow;

  modport master (
    output wr_data,
    output wr_en,
    output flush,
    output Tx_ready,
    input  Tx_in,
    input  send,
    input  full,
    input  empty,
    input  count,
    input  overflow
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    input  flush,
    input  Tx_ready,
    output Tx_in,
    output send,
    output full,
    output empty,
    output count,
    output overflow
  );

endinterface

// File: rtl/uart_tx_feeder_fifo_ram.sv
// Word storage for the feeder FIFO.
// Synchronous write port, asynchronous (show-ahead) read port.
module fifo_ram
  import uart_tx_feeder_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [CeilLog2(DEPTH)-1:0]   waddr,
  input  logic [WORD_LENGHT-1:0]       wdata,
  input  logic [CeilLog2(DEPTH)-1:0]   raddr,
  output logic [WORD_LENGHT-1:0]       rdata
);

  logic [WORD_LENGHT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_feeder.sv
// FIFO-backed word feeder for a UART transmitter.
// Pops one word per frame and enforces an idle gap between frames.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  uart_tx_feeder_if.slave bus
);

  localparam int AW = CeilLog2(DEPTH);
  localparam int CW = CeilLog2(DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ?
                      CeilLog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  state_t state;
  state_t state_next;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic          ovf;
  logic          pop;
  logic          push;
  logic          drop;
  logic          is_full;
  logic          is_empty;

  assign is_full  = (cnt == FULL_CNT);
  assign is_empty = (cnt == '0);

  // Flush and reset both swallow any write in their cycle.
  assign push = rst && !bus.flush && bus.wr_en &&
                (!is_full || pop);
  assign drop = rst && !bus.flush && bus.wr_en &&
                is_full && !pop;

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst && !is_empty && bus.Tx_ready && !bus.flush) begin
          pop        = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.Tx_ready) begin
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = GAP;
            gap_next   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_ONE) begin
          state_next = IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt - GAP_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      if (drop) ovf <= 1'b1;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (push && !pop) cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end
  end

  fifo_ram #(
    .WORD_LENGHT(WORD_LENGHT),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(bus.wr_data),
    .raddr(rd_ptr),
    .rdata(bus.Tx_in)
  );

  assign bus.send     = pop;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;

endmodule
